// File: rtl/vz_loader.sv
// vz_loader: VZ snapshot loader from the hps_io ioctl stream into main RAM, sharing the write port with the Z80.
// Optional VZ_AUTORUN_EN adds an exec_req/exec_addr/exec_ack handshake for machine-code loads.
module vz_loader #(
    parameter logic [7:0]  DN_IDX    = 8'd1,
    parameter int          HDR_LEN   = 24,
    parameter int          STALL_MAX = 16,
    parameter logic [15:0] PTR_ADDR  = 16'h78F9
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dn_download,
    input  logic [7:0]  dn_index,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic        cpu_req,
    output logic        cpu_wait,
    output logic        ram_sel,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [7:0]  file_type,
    output logic [15:0] start_addr,
`ifdef VZ_AUTORUN_EN
    output logic        exec_req,
    output logic [15:0] exec_addr,
    input  logic        exec_ack,
`endif
    output logic [15:0] end_addr
);
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_DRAIN, S_PATCH_LO, S_PATCH_HI, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic        act_q, act_d, pend_q, pend_d, magic_q, magic_d, wait_q, wait_d;
    logic [7:0]  pdata_q, pdata_d, ft_q, ft_d, cnt_q, cnt_d;
    logic [15:0] exp_q, exp_d, ptr_q, ptr_d, start_q, start_d, end_q, end_d;
    logic [1:0]  err_q, err_d;
    logic        start, fall, take, addr_ok, wr_req, wr_now, patch;
    logic [7:0]  magic_ch;
`ifdef VZ_AUTORUN_EN
    logic        exec_q, exec_d;
`endif

    always_comb begin
        act_d    = dn_download && dn_index == DN_IDX;
        start    = act_d && !act_q;
        fall     = act_q && !act_d;
        take     = act_d && dn_wr;
        addr_ok  = dn_addr == exp_q;
        patch    = state_q == S_PATCH_LO || state_q == S_PATCH_HI;
        wr_req   = ((state_q == S_DATA || state_q == S_DRAIN) && pend_q) || patch;
        wr_now   = wr_req && !cpu_req && !reset;
        magic_ch = dn_addr == 16'd0 ? 8'h56 : dn_addr == 16'd1 ? 8'h5A : 8'h46;
        state_d  = state_q;
        pend_d   = pend_q;
        pdata_d  = pdata_q;
        magic_d  = magic_q;
        ft_d     = ft_q;
        exp_d    = exp_q;
        ptr_d    = ptr_q;
        start_d  = start_q;
        end_d    = end_q;
        err_d    = err_q;
        // Stall counter only runs while a write is waiting for a bus gap
        cnt_d    = wr_req && !wr_now ? (cnt_q == 8'(STALL_MAX) ? cnt_q : cnt_q + 8'd1) : 8'd0;
        wait_d   = wr_req && !wr_now && (wait_q || cnt_q == 8'(STALL_MAX - 1));
        if (wr_now && !patch) begin
            pend_d = 1'b0;
            ptr_d  = ptr_q + 16'd1;
            end_d  = ptr_q + 16'd1;
        end
        unique case (state_q)
            S_IDLE: ;
            S_HDR:
                if (fall) begin
                    state_d = S_ERR;
                    err_d   = 2'd3;
                end else if (take) begin
                    if (!addr_ok) begin
                        state_d = S_ERR;
                        err_d   = 2'd2;
                    end else begin
                        exp_d = exp_q + 16'd1;
                        if (dn_addr < 16'd3) magic_d = magic_q && dn_data == magic_ch;
                        if (dn_addr == 16'd3 && !(magic_q && (dn_data == 8'h30 || dn_data == 8'h4F))) begin
                            state_d = S_ERR;
                            err_d   = 2'd1;
                        end
                        if (dn_addr == 16'(HDR_LEN - 3)) ft_d = dn_data;
                        if (dn_addr == 16'(HDR_LEN - 2)) start_d[7:0] = dn_data;
                        if (dn_addr == 16'(HDR_LEN - 1)) begin
                            start_d[15:8] = dn_data;
                            ptr_d         = {dn_data, start_q[7:0]};
                            end_d         = {dn_data, start_q[7:0]};
                            state_d       = S_DATA;
                        end
                    end
                end
            S_DATA:
                if (fall) state_d = S_DRAIN;
                else if (take) begin
                    if (!addr_ok || (pend_q && !wr_now)) begin
                        state_d = S_ERR;
                        err_d   = 2'd2;
                    end else begin
                        pend_d  = 1'b1;
                        pdata_d = dn_data;
                        exp_d   = exp_q + 16'd1;
                    end
                end
            S_DRAIN:    if (!pend_q || wr_now) state_d = ft_q == 8'hF0 ? S_PATCH_LO : S_DONE;
            S_PATCH_LO: if (wr_now) state_d = S_PATCH_HI;
            S_PATCH_HI: if (wr_now) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            S_ERR:      state_d = S_IDLE;
        endcase
`ifdef VZ_AUTORUN_EN
        exec_d = state_q == S_DONE && ft_q == 8'hF1 ? 1'b1 : exec_q && !exec_ack;
        if (start) exec_d = 1'b0;
`endif
        if (start) begin
            state_d = S_HDR;
            err_d   = 2'd0;
            exp_d   = 16'd0;
            pend_d  = 1'b0;
            magic_d = 1'b1;
            cnt_d   = 8'd0;
            wait_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
            act_q   <= 1'b0;
            pend_q  <= 1'b0;
            magic_q <= 1'b0;
            wait_q  <= 1'b0;
            pdata_q <= 8'd0;
            ft_q    <= 8'd0;
            cnt_q   <= 8'd0;
            exp_q   <= 16'd0;
            ptr_q   <= 16'd0;
            start_q <= 16'd0;
            end_q   <= 16'd0;
            err_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            magic_q <= magic_d;
            wait_q  <= wait_d;
            pdata_q <= pdata_d;
            ft_q    <= ft_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            ptr_q   <= ptr_d;
            start_q <= start_d;
            end_q   <= end_d;
            err_q   <= err_d;
        end
    end

`ifdef VZ_AUTORUN_EN
    always_ff @(posedge clk_sys) begin
        if (reset) exec_q <= 1'b0;
        else exec_q <= exec_d;
    end

    assign exec_req  = exec_q;
    assign exec_addr = start_q;
`endif

    assign cpu_wait   = wait_q && wr_req;
    assign ram_sel    = wr_now;
    assign ram_we     = wr_now;
    assign ram_addr   = state_q == S_PATCH_LO ? PTR_ADDR : state_q == S_PATCH_HI ? PTR_ADDR + 16'd1 : ptr_q;
    assign ram_din    = state_q == S_PATCH_LO ? end_q[7:0] : state_q == S_PATCH_HI ? end_q[15:8] : pdata_q;
    assign busy       = state_q == S_HDR || state_q == S_DATA || state_q == S_DRAIN || patch;
    assign done       = state_q == S_DONE;
    assign err        = err_q;
    assign file_type  = ft_q;
    assign start_addr = start_q;
    assign end_addr   = end_q;
endmodule

// File: doc/vz_loader.md
Name: vz_loader

Overview:
- Sequences a VZ snapshot download from the HPS ioctl stream into main RAM.
- Parses the 24-byte VZ header (magic, name, type, start address).
- Shares the RAM write port with the Z80 by slotting single-cycle loader writes between CPU memory cycles.
- Patches the BASIC end-of-program pointer after a BASIC load.
- Sits between hps_io and the LASER310_TOP memory mux.

Parameters:
- DN_IDX, 8'd1, ioctl_index value the block responds to; all other indices are ignored.
- HDR_LEN, 24, header length in bytes.
- STALL_MAX, 16, cycles a pending byte waits for a CPU bus gap before cpu_wait is forced.
- PTR_ADDR, 16'h78F9, BASIC end-pointer location (low byte; high byte at +1).

Ports:
- clk_sys  in  1  system clock (42 MHz)
- reset  in  1  synchronous, active-high reset
- dn_download  in  1  ioctl download active
- dn_index  in  8  ioctl file index
- dn_wr  in  1  byte strobe, one cycle
- dn_addr  in  16  byte offset in file
- dn_data  in  8  byte value
- cpu_req  in  1  CPU memory cycle in progress
- cpu_wait  out  1  forces CPU wait state
- ram_sel  out  1  loader owns RAM port this cycle
- ram_we  out  1  RAM write enable
- ram_addr  out  16  RAM address
- ram_din  out  8  RAM write data
- busy  out  1  load in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  2  0 ok, 1 bad magic, 2 address gap/overrun, 3 short file; sticky until next load
- file_type  out  8  header type byte (F0 BASIC, F1 machine code)
- start_addr  out  16  header load address
- end_addr  out  16  last written address + 1

Behaviour:
- Reset: state IDLE; all outputs 0; err 0; pending buffer empty. Reset mid-load aborts immediately; no further RAM writes.
- Active when dn_download=1 and dn_index=DN_IDX; other indices are invisible to the block.
- IDLE -> HDR on dn_download rising edge with matching index. Action: busy=1, err cleared, expected offset=0.
- HDR:
  - Bytes 0-3 must be "VZF0" or "VZFO"; a mismatch when byte 3 arrives -> ERR, err=1.
  - Byte 21 latches file_type. Bytes 22/23 latch start_addr low/high (little-endian).
  - After byte 23 -> DATA. Write pointer = start_addr; end_addr = start_addr.
- Every dn_wr must carry dn_addr = expected offset; otherwise ERR, err=2.
- DATA:
  - Each byte enters a 1-entry pending buffer. A dn_wr while the buffer is full -> ERR, err=2.
  - The pending byte is written in the first cycle with cpu_req=0: ram_sel=ram_we=1 for exactly 1 cycle, ram_addr=pointer, ram_din=byte.
  - Earliest write is 1 cycle after dn_wr. The pointer then increments and end_addr = pointer+1.
  - Pointer wraps FFFF -> 0000.
- Stall: if the byte has waited STALL_MAX cycles, assert cpu_wait. The write issues at the next cpu_req=0 cycle; cpu_wait drops the cycle after the write.
- dn_download falling edge:
  - In HDR -> ERR, err=3.
  - In DATA -> drain the pending byte, then:
    - file_type=F0: PATCH_LO then PATCH_HI, writing end_addr[7:0] to PTR_ADDR and end_addr[15:8] to PTR_ADDR+1, using the same gap/stall rule.
    - Otherwise -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE. File fields remain valid.
- ERR: busy=0, no RAM writes, -> IDLE. err holds its value.
- A new matching dn_download rising edge in any state restarts at HDR and drops any pending byte.
- ram_sel=0 always implies ram_we=0.

Optional Feature:
- Macro: VZ_AUTORUN_EN.
- When defined:
  - Adds ports exec_req (out, 1), exec_addr (out, 16) and exec_ack (in, 1).
  - On DONE with file_type=F1, exec_req=1 and exec_addr=start_addr, held until exec_ack=1 is sampled; then exec_req=0.
  - Reset or a new load clears exec_req.
- When undefined: these ports do not exist and machine-code loads end at DONE only.

Test Plan:
- Valid BASIC file (header "VZF0", type F0, start 7AE9), 4 payload bytes, cpu_req=0 -> RAM 7AE9..7AEC written in order; 78F9=ED, 78FA=7A; done pulse; err=0.
- Header begins "ABCD" -> ERR at byte 3, err=1, zero ram_we cycles, busy=0.
- Download ends after 10 bytes -> err=3, no RAM writes.
- cpu_req held high 40 cycles with a pending byte -> cpu_wait rises at cycle 16; write occurs on first cpu_req=0 cycle; cpu_wait falls next cycle.
- dn_addr jumps from 30 to 32 -> err=2; a second dn_wr before the pending byte drains -> err=2.
- VZ_AUTORUN_EN, type F1, start 8000 -> exec_req=1, exec_addr=8000 after done; drops the cycle after exec_ack; reset mid-DATA -> ram_sel=0 and exec_req=0 next cycle.
